// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared definitions for the timer APB master slice. Holds the
//            default bus widths, the master FSM state encoding and the timer
//            register map offsets.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int c_addr_w = 12;
    localparam int c_data_w = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Timer register map, byte offsets within the timer APB window
    localparam logic [11:0] c_reg_ctrl   = 12'h000;
    localparam logic [11:0] c_reg_load   = 12'h004;
    localparam logic [11:0] c_reg_value  = 12'h008;
    localparam logic [11:0] c_reg_status = 12'h00C;

endpackage
`default_nettype wire

// File: rtl/timer_apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_master_if
// Purpose  : Bundles the request channel, response channel and timer APB
//            bus of the timer APB master.
// Ports    : modport master - view of the APB master block
//            modport slave  - view of the surrounding requester and timer
// Revision : 1.0 - initial release
// ============================================================================
interface timer_apb_master_if
    import timer_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);

    // Request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_strb;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // Timer APB bus
    logic                  tim_psel;
    logic                  tim_penable;
    logic                  tim_pwrite;
    logic [ADDR_W-1:0]     tim_paddr;
    logic [DATA_W-1:0]     tim_pwdata;
    logic [DATA_W/8-1:0]   tim_pstrb;
    logic [DATA_W-1:0]     tim_prdata;
    logic                  tim_pready;
    logic                  tim_pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_prdata, tim_pready, tim_pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_prdata, tim_pready, tim_pslverr
    );

endinterface
`default_nettype wire

// File: rtl/timer_apb_master_wdog.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_wdog
// Purpose  : ACCESS-phase timeout counter. Cleared on entry to ACCESS,
//            counts every waited ACCESS cycle, flags expiry once the count
//            reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES = 0 never expires.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            i_clr       - restart count from zero
//            i_en        - count one waited cycle
//            o_expired   - count has reached the limit
// Revision : 1.0 - initial release
// ============================================================================
module timer_apb_wdog
    import timer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_limit =
        c_cnt_w'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/timer_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_master
// Purpose  : Turns single valid/ready register commands into two-phase APB
//            transfers on the timer slave port, returns read data and error
//            status on a valid/ready response channel and aborts an ACCESS
//            phase that waits too long. All outputs are registered.
// Ports    : sys_clk  - clock, rising edge
//            sys_rst  - synchronous active-high reset
//            bus      - request, response and timer APB signals (master view)
// Revision : 1.0 - initial release
// ============================================================================
module timer_apb_master
    import timer_pkg::*;
#(
    parameter int ADDR_W         = c_addr_w,
    parameter int DATA_W         = c_data_w,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    timer_apb_master_if.master bus
);

    localparam int c_strb_w = DATA_W / 8;

    state_t                r_state,       w_state;
    logic                  r_req_ready,   w_req_ready;
    logic                  r_psel,        w_psel;
    logic                  r_penable,     w_penable;
    logic                  r_pwrite,      w_pwrite;
    logic [ADDR_W-1:0]     r_paddr,       w_paddr;
    logic [DATA_W-1:0]     r_pwdata,      w_pwdata;
    logic [c_strb_w-1:0]   r_pstrb,       w_pstrb;
    logic                  r_rsp_valid,   w_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata,   w_rsp_rdata;
    logic                  r_rsp_err,     w_rsp_err;
    logic                  r_rsp_timeout, w_rsp_timeout;

    logic                  w_wdog_clr;
    logic                  w_wdog_en;
    logic                  w_wdog_expired;

    // The counter restarts on the SETUP->ACCESS edge and only counts cycles
    // in which the slave is still holding off.
    assign w_wdog_clr = (r_state == ST_SETUP);
    assign w_wdog_en  = (r_state == ST_ACCESS) && !bus.tim_pready;

    timer_apb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .i_clr     (w_wdog_clr),
        .i_en      (w_wdog_en),
        .o_expired (w_wdog_expired)
    );

    always_comb begin
        w_state       = r_state;
        w_req_ready   = r_req_ready;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_pstrb       = r_pstrb;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;

        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid && r_req_ready) begin
                    w_req_ready = 1'b0;
                    w_pwrite    = bus.req_write;
                    w_paddr     = bus.req_addr;
                    // Reads drive zero data and strobes on the bus
                    w_pwdata    = bus.req_write ? bus.req_wdata : '0;
                    w_pstrb     = bus.req_write ? bus.req_strb  : '0;
                    if (bus.req_addr[1:0] == 2'b00) begin
                        w_state = ST_SETUP;
                        w_psel  = 1'b1;
                    end else begin
                        // Misaligned: answer with an error, never touch the bus
                        w_state       = ST_RESP;
                        w_rsp_valid   = 1'b1;
                        w_rsp_err     = 1'b1;
                        w_rsp_timeout = 1'b0;
                        w_rsp_rdata   = '0;
                    end
                end
            end

            ST_SETUP: begin
                w_state   = ST_ACCESS;
                w_penable = 1'b1;
            end

            ST_ACCESS: begin
                // pready wins over an expiry on the same edge
                if (bus.tim_pready) begin
                    w_state       = ST_RESP;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = bus.tim_pslverr;
                    w_rsp_timeout = 1'b0;
                    w_rsp_rdata   = (!r_pwrite && !bus.tim_pslverr) ? bus.tim_prdata : '0;
                end else if (w_wdog_expired) begin
                    w_state       = ST_RESP;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_rdata   = '0;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state       = ST_IDLE;
                    w_req_ready   = 1'b1;
                    w_rsp_valid   = 1'b0;
                    w_rsp_err     = 1'b0;
                    w_rsp_timeout = 1'b0;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_req_ready   <= w_req_ready;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_pstrb       <= w_pstrb;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.tim_psel    = r_psel;
    assign bus.tim_penable = r_penable;
    assign bus.tim_pwrite  = r_pwrite;
    assign bus.tim_paddr   = r_paddr;
    assign bus.tim_pwdata  = r_pwdata;
    assign bus.tim_pstrb   = r_pstrb;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire
